// File: rtl/gpu_spi_pkg.sv
// gpu_spi_pkg: opcodes, frame geometry, FSM state type and payload field offsets for the GPU SPI command link
package gpu_spi_pkg;
    localparam logic [7:0] WRITE_POLY_A   = 8'h80;
    localparam logic [7:0] CLEAR_POLY_A   = 8'h40;
    localparam logic [7:0] WRITE_POLY_B   = 8'h81;
    localparam logic [7:0] CLEAR_POLY_B   = 8'h41;
    localparam logic [7:0] ENABLE_SCREEN  = 8'h21;
    localparam logic [7:0] DISABLE_SCREEN = 8'h20;
    localparam logic [7:0] SET_BG_COLOR   = 8'h01;

    localparam int FRAME_BITS = 56;

    localparam int COLOR_LSB = 0;
    localparam int V0X_LSB   = 6;
    localparam int V1X_LSB   = 13;
    localparam int V2X_LSB   = 20;
    localparam int V0Y_LSB   = 27;
    localparam int V1Y_LSB   = 33;
    localparam int V2Y_LSB   = 39;
    localparam int DEPTH_LSB = 45;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] cmd, input logic [47:0] payload);
        return {payload, cmd};
    endfunction
endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: synchronous command queue
// ports: clk, rst_n (sync, active-low), push/din, pop/dout (head, show-ahead), full, empty
module gpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 60
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic push_ok, pop_ok;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign push_ok = push && !full;
    assign pop_ok = pop && !empty;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= wp == AW'(DEPTH-1) ? '0 : wp + 1'b1;
            if (pop_ok) rp <= rp == AW'(DEPTH-1) ? '0 : rp + 1'b1;
            cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/gpu_spi_cmd_tx.sv
// gpu_spi_cmd_tx: serialises {payload, opcode} 56-bit frames LSB first onto an SPI link (mode 0, CS active low)
// ports: clk, rst_n (sync, active-low); cmd_valid/cmd_ready/cmd_byte/cmd_payload command input;
//        clk_div (SCK half period = clk_div+1 clocks); tx_allow gates SCK rising edges;
//        sck_out, cs_out, mosi_out SPI pins; busy, frame_done status
// GPU_SPI_CMD_FIFO_EN: when defined, commands are buffered in a FIFO_DEPTH-entry queue
module gpu_spi_cmd_tx import gpu_spi_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic [47:0] cmd_payload,
    input  logic [3:0]  clk_div,
    input  logic        tx_allow,
    output logic        sck_out,
    output logic        cs_out,
    output logic        mosi_out,
    output logic        busy,
    output logic        frame_done
);
    state_t state;
    logic [FRAME_BITS-1:0] sh, next_frame;
    logic [3:0] div, next_div;
    logic [5:0] cnt, bits;
    logic half_end, gap_end, start;

    // cnt counts clocks within a phase; a half period ends at H-1 = div, the gap at 2H-1
    assign half_end = cnt == {2'b00, div};
    assign gap_end = state == GAP && cnt == {1'b0, div, 1'b1};

`ifdef GPU_SPI_CMD_FIFO_EN
    logic full, empty;
    logic [FRAME_BITS+3:0] head;
    gpu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(FRAME_BITS+4)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(cmd_valid && cmd_ready),
        .din({clk_div, make_frame(cmd_byte, cmd_payload)}),
        .pop(start),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    // a queued command launches straight out of the last GAP cycle so frames stay 2H apart
    always_comb begin
        cmd_ready = !full;
        start = !empty && (state == IDLE || gap_end);
        {next_div, next_frame} = head;
    end
`else
    logic unused_depth;
    assign unused_depth = FIFO_DEPTH[0];
    always_comb begin
        cmd_ready = state == IDLE;
        start = cmd_valid && cmd_ready;
        next_frame = make_frame(cmd_byte, cmd_payload);
        next_div = clk_div;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bits <= '0;
            sh <= '0;
            div <= '0;
        end else if (start) begin
            state <= SETUP;
            cnt <= '0;
            bits <= '0;
            sh <= next_frame;
            div <= next_div;
        end else begin
            case (state)
                SETUP, LOW: begin
                    // a finished low phase waits here, cnt saturated, until a rising edge is allowed
                    if (half_end && state == LOW && bits == 6'(FRAME_BITS)) begin
                        state <= GAP;
                        cnt <= '0;
                    end else if (half_end && tx_allow) begin
                        state <= HIGH;
                        cnt <= '0;
                    end else if (!half_end) cnt <= cnt + 6'd1;
                end
                HIGH: begin
                    if (half_end) begin
                        state <= LOW;
                        cnt <= '0;
                        sh <= sh >> 1;
                        bits <= bits + 6'd1;
                    end else cnt <= cnt + 6'd1;
                end
                GAP: begin
                    if (gap_end) state <= IDLE;
                    else cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign sck_out = state == HIGH;
    assign cs_out = !(state == SETUP || state == HIGH || state == LOW);
    assign mosi_out = !cs_out && sh[0];
    assign busy = state != IDLE;
    assign frame_done = gap_end;
endmodule

// File: tb/tb_gpu_spi_cmd_tx.sv
// tb_gpu_spi_cmd_tx: SPI receiver model plus table, corner-case and random checks for gpu_spi_cmd_tx
module tb_gpu_spi_cmd_tx;
    import gpu_spi_pkg::*;

    logic clk = 0, rst_n = 0, cmd_valid = 0, tx_allow = 1;
    logic [7:0] cmd_byte = '0;
    logic [47:0] cmd_payload = '0;
    logic [3:0] clk_div = '0;
    logic cmd_ready, sck_out, cs_out, mosi_out, busy, frame_done;
    int tests = 0, fails = 0;

    gpu_spi_cmd_tx dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_byte(cmd_byte),
        .cmd_payload(cmd_payload),
        .clk_div(clk_div),
        .tx_allow(tx_allow),
        .sck_out(sck_out),
        .cs_out(cs_out),
        .mosi_out(mosi_out),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // receiver: shifts mosi in LSB first on each sck rise, measures cs low/high runs and gap lengths
    logic prev_sck = 0, prev_cs = 1, ta;
    logic [55:0] rx = '0;
    int rises = 0, cslow = 0, csh = 0, gapc = 0, dones = 0, viol = 0;
    logic [55:0] q_frame[$];
    int q_rises[$], q_cslow[$], q_csh[$], q_gap[$];

    always @(posedge clk) begin
        ta = tx_allow;
        #1;
        if (prev_cs && !cs_out) begin
            q_csh.push_back(csh);
            rx = '0;
            rises = 0;
            cslow = 0;
        end
        if (!prev_cs && cs_out) begin
            q_frame.push_back(rx);
            q_rises.push_back(rises);
            q_cslow.push_back(cslow);
            csh = 0;
            gapc = 0;
        end
        if (!cs_out) cslow++;
        else csh++;
        if (cs_out && busy) gapc++;
        if (frame_done) begin
            dones++;
            q_gap.push_back(gapc);
        end
        if (!prev_sck && sck_out) begin
            rises++;
            rx = {mosi_out, rx[55:1]};
            if (!ta) viol++;
        end
        prev_sck = sck_out;
        prev_cs = cs_out;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timeout", nm);
    endtask

    task automatic send(input logic [7:0] c, input logic [47:0] p, input logic [3:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1;
        cmd_byte = c;
        cmd_payload = p;
        clk_div = d;
        while (!cmd_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout("send");
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_frame(input string nm, output logic [55:0] f, output int r, output int c);
        int n = 0;
        f = '0;
        r = -1;
        c = -1;
        while (q_frame.size() == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (q_frame.size() == 0) timeout(nm);
        else begin
            f = q_frame.pop_front();
            r = q_rises.pop_front();
            c = q_cslow.pop_front();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout("wait_idle");
    endtask

    task automatic flush();
        q_frame.delete();
        q_rises.delete();
        q_cslow.delete();
        q_csh.delete();
        q_gap.delete();
    endtask

    function automatic int pop_gap();
        return q_gap.size() > 0 ? q_gap.pop_front() : -1;
    endfunction

    typedef struct {
        logic [7:0]  cmd;
        logic [47:0] pl;
        logic [3:0]  div;
        logic [55:0] exp_f;
        int          exp_cs;
    } vec_t;

    vec_t v[4];
    logic [55:0] f;
    logic [55:0] fa [3];
    int r, c, ed, n, sck_hi;
    logic [7:0] rc;
    logic [47:0] rp;
    logic [3:0] rd;

    initial begin
        v[0] = '{ENABLE_SCREEN, 48'h0, 4'd1, 56'h21, 226};
        v[1] = '{WRITE_POLY_A, 48'hA5A5_5A5A_F00F, 4'd2, 56'hA5A55A5AF00F80, 339};
        v[2] = '{SET_BG_COLOR, 48'h3F, 4'd0, 56'h3F01, 113};
        v[3] = '{CLEAR_POLY_B, 48'hFFFF_FFFF_FFFF, 4'd15, 56'hFFFFFFFFFFFF41, 1808};
        ed = 0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {cs_out, sck_out, mosi_out, busy, frame_done, cmd_ready}, 6'b100001);
        rst_n = 1;
        @(negedge clk);
        chk("after_reset_ready", {cs_out, busy, cmd_ready}, 3'b101);

        for (int i = 0; i < 4; i++) begin
            send(v[i].cmd, v[i].pl, v[i].div);
            wait_frame("table_frame", f, r, c);
            wait_idle();
            ed++;
            chk($sformatf("table%0d_frame", i), f, v[i].exp_f);
            chk($sformatf("table%0d_rises", i), r, 56);
            chk($sformatf("table%0d_cs_low", i), c, v[i].exp_cs);
            chk($sformatf("table%0d_gap", i), pop_gap(), 2 * (v[i].div + 1));
            chk($sformatf("table%0d_done_count", i), dones, ed);
        end

        // pause after 10th rise
        send(CLEAR_POLY_A, 48'h1234_5678_9ABC, 4'd1);
        n = 0;
        while (rises < 10 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rises < 10) timeout("pause_reach10");
        tx_allow = 0;
        sck_hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i >= 4 && sck_out) sck_hi++;
        end
        chk("pause_sck_low", sck_hi, 0);
        chk("pause_no_rises", rises, 10);
        tx_allow = 1;
        wait_frame("pause_frame", f, r, c);
        wait_idle();
        ed++;
        void'(pop_gap());
        chk("pause_frame", f, 56'h123456789ABC40);
        chk("pause_rises", r, 56);
        chk("pause_cs_low_stretched", c > 226, 1);

        // reset at bit 30
        send(WRITE_POLY_B, 48'hDEAD_BEEF_CAFE, 4'd0);
        n = 0;
        while (rises < 31 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rises < 31) timeout("reset_reach30");
        rst_n = 0;
        @(negedge clk);
        chk("midframe_reset", {cs_out, sck_out, mosi_out, busy, frame_done, cmd_ready}, 6'b100001);
        rst_n = 1;
        flush();
        send(SET_BG_COLOR, 48'h3F, 4'd0);
        wait_frame("post_reset_frame", f, r, c);
        wait_idle();
        ed++;
        chk("post_reset_frame", f, 56'h3F01);
        chk("post_reset_rises", r, 56);
        chk("post_reset_gap", pop_gap(), 2);
        chk("post_reset_done_count", dones, ed);

        // three back-to-back commands
        flush();
        fa[0] = {48'h0000_0000_0011, DISABLE_SCREEN};
        fa[1] = {48'h0000_0000_0022, ENABLE_SCREEN};
        fa[2] = {48'h0000_0000_0033, SET_BG_COLOR};
`ifdef GPU_SPI_CMD_FIFO_EN
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            cmd_valid = 1;
            cmd_byte = fa[j][7:0];
            cmd_payload = fa[j][55:8];
            clk_div = 4'd0;
            chk("fifo_ready", cmd_ready, 1);
        end
        @(negedge clk);
        cmd_valid = 0;
`else
        send(fa[0][7:0], fa[0][55:8], 4'd0);
        @(negedge clk);
        cmd_valid = 1;
        cmd_byte = fa[1][7:0];
        cmd_payload = fa[1][55:8];
        for (int j = 0; j < 5; j++) begin
            chk("ready_low_while_busy", {busy, cmd_ready}, 2'b10);
            @(negedge clk);
        end
        cmd_valid = 0;
        send(fa[1][7:0], fa[1][55:8], 4'd0);
        send(fa[2][7:0], fa[2][55:8], 4'd0);
`endif
        for (int j = 0; j < 3; j++) begin
            wait_frame("b2b_frame", f, r, c);
            chk($sformatf("b2b%0d_frame", j), f, fa[j]);
            chk($sformatf("b2b%0d_rises", j), r, 56);
        end
        wait_idle();
`ifdef GPU_SPI_CMD_FIFO_EN
        chk("b2b_sep1", q_csh.size() >= 3 ? q_csh[1] : -1, 2);
        chk("b2b_sep2", q_csh.size() >= 3 ? q_csh[2] : -1, 2);
`endif
        ed += 3;
        chk("b2b_done_count", dones, ed);
        flush();

        // random commands with random tx_allow throttling
        for (int k = 0; k < 12; k++) begin
            rc = 8'($urandom);
            rp = {16'($urandom), 32'($urandom)};
            rd = 4'($urandom_range(0, 3));
            send(rc, rp, rd);
            n = 0;
            while (q_frame.size() == 0 && n < 40000) begin
                @(negedge clk);
                tx_allow = $urandom_range(0, 3) != 0;
                n++;
            end
            tx_allow = 1;
            wait_frame("rnd_frame", f, r, c);
            wait_idle();
            ed++;
            chk($sformatf("rnd%0d_frame", k), f, {rp, rc});
            chk($sformatf("rnd%0d_rises", k), r, 56);
            chk($sformatf("rnd%0d_cs_low_min", k), c >= 113 * (rd + 1), 1);
            chk($sformatf("rnd%0d_gap", k), pop_gap(), 2 * (rd + 1));
        end
        chk("rnd_done_count", dones, ed);
        chk("rise_only_with_allow", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
